data_mem_responder: RTL

//  Memory-side responder for the core's load/store port. Serves byte/half/word loads and stores

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Load/store request and response channels between the core
//               (master) and the data memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-organised data memory serving byte/half/word loads and
//               stores with a programmable number of wait states and a single
//               outstanding transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active low
  data_mem_responder_if.slave bus
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int          CNT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_LOAD_I);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    func3_q, func3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // The request being resolved: live inputs while idle (zero-wait commit
  // happens on the accept edge itself), otherwise the latched copy.
  logic          sel_we;
  logic [2:0]    sel_func3;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          req_err;
  logic          enter_resp;
  logic          mem_we;

  assign bus.req_ready = (state_q == ST_IDLE) && rst;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Decode the selected request: legality, load lane extraction, store lanes.
  always_comb begin
    sel_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    sel_func3 = (state_q == ST_IDLE) ? bus.req_func3 : func3_q;
    sel_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    sel_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

    word_idx  = sel_addr[AW+1:2];
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {sel_addr[1:0], 3'b000};
    rd_half   = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];

    req_err = 1'b0;
    if (sel_func3 == 3'd3 || sel_func3 == 3'd6 || sel_func3 == 3'd7) req_err = 1'b1;
    if (sel_we && sel_func3[2]) req_err = 1'b1;
    if (sel_func3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00) req_err = 1'b1;
    if (sel_func3[1:0] == 2'b01 && sel_addr[0]) req_err = 1'b1;
    if ({1'b0, sel_addr} >= ADDR_LIMIT) req_err = 1'b1;

    load_data = 32'h0;
    case (sel_func3)
      3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'h0, rd_shift[7:0]};
      3'd5:    load_data = {16'h0, rd_half};
      default: load_data = 32'h0;
    endcase

    wr_be   = 4'b0000;
    wr_data = sel_wdata;
    case (sel_func3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << sel_addr[1:0];
        wr_data = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = sel_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{sel_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Next-state, wait counter, request latch and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          func3_d = bus.req_func3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    mem_we     = enter_resp && sel_we && !req_err;
    if (enter_resp) begin
      rdata_d = (sel_we || req_err) ? 32'h0 : load_data;
      err_d   = req_err;
    end
  end

  // Control and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane store commit; contents survive reset, and nothing commits
  // while reset is held.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
